// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter:
// FSM state encoding and the counter width helper.
package piso_serializer_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Counters need at least one bit even when the modulus is 1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake plus serial link signals of the transmitter.
interface piso_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              serial_out;
    logic              frame_out;
    logic              done;

    modport master (
        output data_in, valid_in,
        input  ready_out, serial_out, frame_out, done
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, serial_out, frame_out, done
    );
endinterface

// File: rtl/piso_serializer_bit_timer.sv
// Modulo-CLKS_PER_BIT clock counter; tc flags the final clock of a bit period.
module piso_serializer_bit_timer
    import piso_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_reg;

    assign tc = (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= tc ? '0 : cnt_reg + W'(1);
        end
    end
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one word per frame, each bit held
// CLKS_PER_BIT clocks, frame_out qualifying every data cycle.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);
    localparam int BW = cnt_width(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    logic [0:0]        state_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [DATA_W-1:0] shreg_next;
    logic [BW-1:0]     bit_cnt_reg;
    logic              serial_reg;
    logic              frame_reg;
    logic              done_reg;
    logic              first_bit;
    logic              next_bit;
    logic              bit_end;
    logic              accept;
    logic              last_bit;

    assign accept   = bus.valid_in && (state_reg == IDLE);
    assign last_bit = (bit_cnt_reg == BIT_LAST);

    // The next bit to send always sits at the outgoing end of the shifted word.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shreg_next = shreg_reg << 1;
            assign first_bit  = bus.data_in[DATA_W-1];
            assign next_bit   = shreg_next[DATA_W-1];
        end else begin : g_lsb
            assign shreg_next = shreg_reg >> 1;
            assign first_bit  = bus.data_in[0];
            assign next_bit   = shreg_next[0];
        end
    endgenerate

    piso_serializer_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (state_reg == SHIFT),
        .tc     (bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            serial_reg  <= 1'b0;
            frame_reg   <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (bus.valid_in) begin
                    state_reg   <= SHIFT;
                    shreg_reg   <= bus.data_in;
                    bit_cnt_reg <= '0;
                    serial_reg  <= first_bit;
                    frame_reg   <= 1'b1;
                end
            end else if (bit_end) begin
                if (last_bit) begin
                    state_reg   <= IDLE;
                    bit_cnt_reg <= '0;
                    serial_reg  <= 1'b0;
                    frame_reg   <= 1'b0;
                    done_reg    <= 1'b1;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + BW'(1);
                    shreg_reg   <= shreg_next;
                    serial_reg  <= next_bit;
                end
            end
        end
    end

    assign bus.ready_out  = (state_reg == IDLE);
    assign bus.serial_out = serial_reg;
    assign bus.frame_out  = frame_reg;
    assign bus.done       = done_reg;
endmodule
